// File: rtl/fp_pkg.sv
// Shared types and constants for the iterative single-precision divider.
// Rounding mode is selected by the FPD_RNE_EN macro (see fpd_iter).
package fp_pkg;

    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_MAX   = 255;
    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam int          MANT_W    = 23;
    localparam int          DIV_ITERS = 26;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_NORM,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        C_ZERO,
        C_NORM,
        C_INF,
        C_NAN
    } fclass_t;

    function automatic logic [31:0] signed_inf(input logic s);
        return {s, 8'(EXP_MAX), {MANT_W{1'b0}}};
    endfunction

    function automatic logic [31:0] signed_zero(input logic s);
        return {s, 31'd0};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; denormals are reported as zero.
// Ports: x = exponent+mantissa field of an IEEE-754 single, cls = class.
module fp_classify
    import fp_pkg::*;
(
    input  logic [30:0] x,
    output fclass_t     cls
);

    always_comb begin
        cls = C_NORM;
        if (x[30:23] == 8'h00)
            cls = C_ZERO;
        else if (x[30:23] == 8'hFF)
            cls = (x[22:0] == '0) ? C_INF : C_NAN;
    end

endmodule

// File: rtl/fpd_iter.sv
// Iterative IEEE-754 single divider: restoring mantissa division, 28-edge
// fixed latency. Ports: clk, rst (async high), start, a, b -> c, busy, done,
// dz, nv. Define FPD_RNE_EN for round-to-nearest-even, else truncation.
module fpd_iter
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic        nv
);

    state_t            state, nxt;
    fclass_t           cls_a, cls_b, ca, cb;
    logic              sgn;
    logic [4:0]        cnt;
    logic signed [9:0] ediff, exp_r, exp_q, exp_n;
    logic [23:0]       dvs;
    logic [25:0]       rem, q;
    logic [24:0]       diff;
    logic              ge;
    logic [MANT_W-1:0] frac_r, frac_n;
    logic [23:0]       m24;
    logic [24:0]       m25;
    logic              rup;
    logic [31:0]       res;
    logic              res_dz, res_nv;
    logic              accept;

    fp_classify u_cls_a (.x(a[30:0]), .cls(cls_a));
    fp_classify u_cls_b (.x(b[30:0]), .cls(cls_b));

    assign accept = (state == S_IDLE) && start;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = S_DIV;
            S_DIV:   if (cnt == 5'(DIV_ITERS - 1)) nxt = S_NORM;
            S_NORM:  nxt = S_FIN;
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Remainder stays below 2*divisor, so the difference fits in 25 bits.
    assign ge   = rem >= {2'b00, dvs};
    assign diff = rem[24:0] - {1'b0, dvs};

    always_comb begin
        m24   = q[25] ? q[25:2] : q[24:1];
        exp_q = q[25] ? ediff : ediff - 10'sd1;
`ifdef FPD_RNE_EN
        // Guard decides; the dropped round bit and remainder form sticky.
        rup = (q[25] ? q[1] : q[0])
            & (m24[0] | (q[25] & q[0]) | (|rem));
`else
        rup = 1'b0;
`endif
        m25    = {1'b0, m24} + {24'd0, rup};
        frac_n = m25[24] ? m25[23:1] : m25[22:0];
        exp_n  = exp_q + {9'd0, m25[24]};
    end

    always_comb begin
        res    = '0;
        res_dz = 1'b0;
        res_nv = 1'b0;
        if (ca == C_NAN || cb == C_NAN ||
            (ca == C_ZERO && cb == C_ZERO) ||
            (ca == C_INF && cb == C_INF)) begin
            res    = QNAN;
            res_nv = 1'b1;
        end else if (cb == C_ZERO) begin
            res    = signed_inf(sgn);
            res_dz = (ca != C_INF);
        end else if (ca == C_INF) begin
            res = signed_inf(sgn);
        end else if (cb == C_INF || ca == C_ZERO) begin
            res = signed_zero(sgn);
        end else if (exp_r < 10'sd1) begin
            res = signed_zero(sgn);
        end else if (exp_r >= 10'(EXP_MAX)) begin
            res = signed_inf(sgn);
        end else begin
            res = {sgn, exp_r[7:0], frac_r};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ca     <= C_ZERO;
            cb     <= C_ZERO;
            sgn    <= 1'b0;
            cnt    <= '0;
            ediff  <= '0;
            dvs    <= '0;
            rem    <= '0;
            q      <= '0;
            exp_r  <= '0;
            frac_r <= '0;
            c      <= '0;
            done   <= 1'b0;
            dz     <= 1'b0;
            nv     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ca    <= cls_a;
                cb    <= cls_b;
                sgn   <= a[31] ^ b[31];
                ediff <= $signed({2'b00, a[30:23]})
                       - $signed({2'b00, b[30:23]})
                       + 10'(EXP_BIAS);
                dvs   <= {1'b1, b[MANT_W-1:0]};
                rem   <= {2'b01, a[MANT_W-1:0]};
                q     <= '0;
                cnt   <= '0;
            end
            if (state == S_DIV) begin
                rem <= {(ge ? diff : rem[24:0]), 1'b0};
                q   <= {q[24:0], ge};
                cnt <= cnt + 5'd1;
            end
            if (state == S_NORM) begin
                exp_r  <= exp_n;
                frac_r <= frac_n;
            end
            if (state == S_FIN) begin
                c    <= res;
                dz   <= res_dz;
                nv   <= res_nv;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpd_iter.sv
// Self-checking bench for fpd_iter: directed vectors, random operands
// against an integer-arithmetic reference, start-ignore and reset abort.
module tb_fpd_iter;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] c;
    logic        busy, done, dz, nv;

    int total = 0;
    int bad = 0;

    fpd_iter dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .c(c), .busy(busy), .done(done), .dz(dz), .nv(nv)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic d,
                                  output logic n);
        int ex, ey, e, sh;
        logic s;
        bit xz, xi, xn, yz, yi, yn;
        longint unsigned ma, mb, num, qt, rm, m;
`ifdef FPD_RNE_EN
        longint unsigned rest, half;
`endif
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        d = 1'b0;
        n = 1'b0;
        r = '0;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            r = 32'h7FC00000;
            n = 1'b1;
        end else if (yz) begin
            r = {s, 8'hFF, 23'd0};
            d = !xi;
        end else if (xi) begin
            r = {s, 8'hFF, 23'd0};
        end else if (yi || xz) begin
            r = {s, 31'd0};
        end else begin
            e   = ex - ey + 127;
            ma  = 64'(x[22:0]) + (64'd1 << 23);
            mb  = 64'(y[22:0]) + (64'd1 << 23);
            num = ma << 40;
            qt  = num / mb;
            rm  = num % mb;
            if (qt >= (64'd1 << 40)) sh = 17;
            else begin
                sh = 16;
                e  = e - 1;
            end
            m = qt >> sh;
`ifdef FPD_RNE_EN
            rest = qt & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rest > half || (rest == half && (rm != 0 || m[0])))
                m = m + 1;
`else
            if (rm == 0) m = m + 0;
`endif
            if (m == (64'd1 << 24)) begin
                m = m >> 1;
                e = e + 1;
            end
            if (e <= 0)        r = {s, 31'd0};
            else if (e >= 255) r = {s, 8'hFF, 23'd0};
            else               r = {s, 8'(e), m[22:0]};
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: v[30:23] = 8'h00;
            1: v[30:0]  = {8'hFF, 23'd0};
            2: begin
                v[30:23] = 8'hFF;
                if (v[22:0] == 0) v[0] = 1'b1;
            end
            3, 4: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input string tag);
        logic [31:0] er;
        logic ed, en;
        int lat;
        model(x, y, er, ed, en);
        @(posedge clk); #1;
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start got=%b exp=1", tag, busy);
        end
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) lat = k;
        end
        total++;
        if (lat !== 28) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=28", tag, lat);
        end
        total++;
        if (c !== er || dz !== ed || nv !== en || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s a=%h b=%h c=%h dz=%b nv=%b busy=%b exp c=%h dz=%b nv=%b busy=0",
                     tag, x, y, c, dz, nv, busy, er, ed, en);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || c !== er) begin
            bad++;
            $display("FAIL %s hold done=%b c=%h exp done=0 c=%h", tag, done, c, er);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (c !== 32'd0 || busy !== 1'b0 || done !== 1'b0 ||
            dz !== 1'b0 || nv !== 1'b0) begin
            bad++;
            $display("FAIL reset c=%h busy=%b done=%b dz=%b nv=%b exp all 0",
                     c, busy, done, dz, nv);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        run_op(32'h3FC00000, 32'h3F400000, "exact_two");
        run_op(32'h3F980000, 32'h3F100000, "rounding");
        run_op(32'h3F800000, 32'h00000000, "div_zero");
        run_op(32'h00000000, 32'h00000000, "zero_zero");
        run_op(32'h7F000000, 32'h3F000000, "overflow");
        run_op(32'h00800000, 32'h4B000000, "underflow");
        run_op(32'hFF800000, 32'h3F800000, "inf_fin");
        run_op(32'h3F800000, 32'hFF800000, "fin_inf");
        run_op(32'h7F800000, 32'h7F800000, "inf_inf");
        run_op(32'h7FC00001, 32'h3F800000, "nan_op");
        run_op(32'h80000000, 32'h3F800000, "neg_zero");
        run_op(32'h3F800000, 32'h3F7FFFFF, "carry_near");
        run_op(32'h00400000, 32'h3F800000, "denorm_in");
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++)
            run_op(rnd_op(), rnd_op(), "random");
    endtask

    task automatic test_ignore_start();
        logic [31:0] er;
        logic ed, en;
        int lat, extra;
        model(32'h40490FDB, 32'h402DF854, er, ed, en);
        @(posedge clk); #1;
        a = 32'h40490FDB; b = 32'h402DF854; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        a = 32'h3F800000; b = 32'h00000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 7; k <= 40 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) lat = k;
        end
        total++;
        if (lat !== 28) begin
            bad++;
            $display("FAIL ignore_latency got=%0d exp=28", lat);
        end
        total++;
        if (c !== er || dz !== ed || nv !== en) begin
            bad++;
            $display("FAIL ignore_result c=%h dz=%b nv=%b exp c=%h dz=%b nv=%b",
                     c, dz, nv, er, ed, en);
        end
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ignore_queued busy_cycles=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        run_op(32'h3FC00000, 32'h3F400000, "pre_abort");
        @(posedge clk); #1;
        a = 32'h40400000; b = 32'h3F800000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || c !== 32'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_async busy=%b c=%h done=%b exp 0 0 0",
                     busy, c, done);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_done pulses=%0d exp=0", seen);
        end
        run_op(32'h3F980000, 32'h3F100000, "post_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpd_iter.md
FPD_ITER -- requirements
Module: fpd_iter

Interface
REQ-001 SHALL declare port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL declare port: rst  input  1  reset, asynchronous and active-high; one clock (clk).
REQ-003 SHALL declare port: start  input  1  request to begin a division, sampled on a clk edge.
REQ-004 SHALL declare port: a  input  32  IEEE-754 single-precision dividend, sampled with start.
REQ-005 SHALL declare port: b  input  32  IEEE-754 single-precision divisor, sampled with start.
REQ-006 SHALL declare port: c  output  32  quotient a/b.
REQ-007 SHALL declare port: busy  output  1  operation in progress.
REQ-008 SHALL declare port: done  output  1  one-cycle pulse when c is valid.
REQ-009 SHALL declare port: dz  output  1  divide-by-zero flag, valid with done.
REQ-010 SHALL declare port: nv  output  1  invalid-operation flag, valid with done.

Function
REQ-011 SHALL use a 4-state FSM: IDLE, DIV, NORM, FIN.
- IDLE->DIV: start=1.
- DIV->NORM: after 26 iterations.
- NORM->FIN: unconditionally.
- FIN->IDLE: unconditionally.
REQ-012 SHALL capture a and b only on the start edge taken in IDLE; start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-013 SHALL assert busy from the accepting edge until the edge that enters IDLE.
REQ-014 SHALL pulse done for exactly one cycle, 28 clk edges after the accepting edge, for all operand classes (constant latency).
REQ-015 SHALL hold c, dz and nv stable from done until the next accepted start.
REQ-016 SHALL compute the result sign as sign(a) XOR sign(b), including for zero and infinite results.
REQ-017 SHALL compute the biased exponent as ea - eb + 127 in a 10-bit signed intermediate; SHALL decrement it by 1 when the mantissa quotient is < 1.
REQ-018 SHALL divide the 24-bit mantissa {1,ma} by {1,mb} by restoring division, one quotient bit per DIV cycle.
- 26 quotient bits total.
- Sticky bit = OR of the final remainder.
REQ-019 SHALL, in NORM, left-shift the quotient by 1 when its MSB is 0, then round to 24 bits (see Configuration).
REQ-020 SHALL propagate a rounding carry out of the mantissa into the exponent.
REQ-021 SHALL flush denormal inputs to signed zero; SHALL return signed zero when the final exponent <= 0.
REQ-022 SHALL return signed infinity (exponent 255, mantissa 0) when the final exponent >= 255.
REQ-023 SHALL apply these special cases, which override the arithmetic result:
- NaN operand, 0/0 or inf/inf: c=0x7FC00000, nv=1.
- Finite nonzero/0: signed infinity, dz=1.
- inf/finite: signed infinity.
- finite/inf: signed zero.

Reset
REQ-024 SHALL, on rst=1, immediately drive FSM=IDLE, c=0, busy=0, done=0, dz=0, nv=0 and clear all datapath registers, independent of clk.
REQ-025 SHALL abort any operation in flight on reset, with no done pulse for it; the first start after rst is released SHALL behave as after power-up.

Configuration
REQ-026 SHALL use macro FPD_RNE_EN.
- Defined: round-to-nearest-even using guard bit, round bit and sticky bit.
- Undefined: truncate toward zero and drop guard/round/sticky logic.
- Latency SHALL be identical in both builds.

Structure
REQ-027 SHALL place the following in shared package fp_pkg:
- Constants: EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MANT_W=23, DIV_ITERS=26.
- An enumerated FSM state type.
- An operand-class type: ZERO, NORM, INF, NAN.
REQ-028 SHALL contain one sub-module, fp_classify: combinational operand classifier, instanced twice (for a and b).

Verification
REQ-029 SHALL check: a=0x3FC00000, b=0x3F400000 -> c=0x40000000, dz=0, nv=0, done exactly 28 edges after start.
REQ-030 SHALL check: a=0x3F980000, b=0x3F100000 -> c=0x40071C72 with FPD_RNE_EN defined; c=0x40071C71 without it.
REQ-031 SHALL check: a=0x3F800000, b=0x00000000 -> c=0x7F800000, dz=1; and a=0, b=0 -> c=0x7FC00000, nv=1.
REQ-032 SHALL check: a=0x7F000000, b=0x3F000000 -> c=0x7F800000 (overflow); and a=0x00800000, b=0x4B000000 -> c=0x00000000 (underflow).
REQ-033 SHALL check: second start 5 cycles into an operation is ignored, and the first result is delivered unchanged.
REQ-034 SHALL check: rst pulsed 10 cycles into an operation -> busy=0 and c=0 immediately, with no done pulse; a new start afterwards completes normally.
